fsign_class_unit: RTL and testbench

//  2-stage pipelined FPU execute unit for the sign-manipulation / classify group:

---
 rtl/fsign_class_unit.sv | 129 ++++++++++++
 tb/tb_fsign_class_unit.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/fsign_class_unit.sv
// Two-stage FPU execute unit for sign injection, classify and FMV.X.W.
// S1 registers the request and pre-decodes the operand fields; S2 forms the result.
module fsign_class_unit #(
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [31:0]      in_x1,
  input  logic [31:0]      in_x2,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_err,
  output logic             busy
);

  localparam logic [2:0] OP_SGNJ  = 3'b000;
  localparam logic [2:0] OP_SGNJN = 3'b001;
  localparam logic [2:0] OP_SGNJX = 3'b010;
  localparam logic [2:0] OP_CLASS = 3'b011;
  localparam logic [2:0] OP_MVXW  = 3'b100;

  logic             s1_valid;
  logic [2:0]       s1_op;
  logic [31:0]      s1_x1;
  logic [TAG_W-1:0] s1_tag;
  logic             s1_sgn2;
  logic             s1_exp_ones;
  logic             s1_exp_zero;
  logic             s1_man_zero;
  logic             s1_quiet;

  logic             s2_adv;
  logic             s1_adv;
  logic             accept;
  logic [9:0]       cls;
  logic [31:0]      res_data;
  logic             res_err;

  // Handshake: a transfer happens on an edge where valid and ready are both high.
  assign s2_adv   = !out_valid || out_ready;
  assign s1_adv   = s1_valid && s2_adv;
  assign in_ready = !rst && (!s1_valid || s2_adv);
  assign accept   = in_valid && in_ready;
  assign busy     = s1_valid || out_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid    <= 1'b0;
      s1_op       <= 3'b000;
      s1_x1       <= 32'h0;
      s1_tag      <= '0;
      s1_sgn2     <= 1'b0;
      s1_exp_ones <= 1'b0;
      s1_exp_zero <= 1'b0;
      s1_man_zero <= 1'b0;
      s1_quiet    <= 1'b0;
    end else if (accept) begin
      s1_valid    <= 1'b1;
      s1_op       <= in_op;
      s1_x1       <= in_x1;
      s1_tag      <= in_tag;
      s1_sgn2     <= in_x2[31];
      s1_exp_ones <= (in_x1[30:23] == 8'hFF);
      s1_exp_zero <= (in_x1[30:23] == 8'h00);
      s1_man_zero <= (in_x1[22:0] == 23'h0);
      s1_quiet    <= in_x1[22];
    end else if (s1_adv) begin
      s1_valid    <= 1'b0;
    end
  end

  // One-hot class; NaN classes ignore the sign bit.
  always_comb begin
    cls = 10'b0;
    if (s1_exp_ones && !s1_man_zero) begin
      if (s1_quiet) cls[9] = 1'b1;
      else          cls[8] = 1'b1;
    end else if (s1_exp_ones) begin
      if (s1_x1[31]) cls[0] = 1'b1;
      else           cls[7] = 1'b1;
    end else if (s1_exp_zero && s1_man_zero) begin
      if (s1_x1[31]) cls[3] = 1'b1;
      else           cls[4] = 1'b1;
    end else if (s1_exp_zero) begin
      if (s1_x1[31]) cls[2] = 1'b1;
      else           cls[5] = 1'b1;
    end else begin
      if (s1_x1[31]) cls[1] = 1'b1;
      else           cls[6] = 1'b1;
    end
  end

  always_comb begin
    res_data = 32'h0;
    res_err  = 1'b0;
    case (s1_op)
      OP_SGNJ:  res_data = {s1_sgn2, s1_x1[30:0]};
      OP_SGNJN: res_data = {~s1_sgn2, s1_x1[30:0]};
      OP_SGNJX: res_data = {s1_x1[31] ^ s1_sgn2, s1_x1[30:0]};
      OP_CLASS: res_data = {22'b0, cls};
      OP_MVXW:  res_data = s1_x1;
      default:  res_err  = 1'b1;
    endcase
  end

  // Output register only loads on s2_adv, so a stalled result stays put.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= 32'h0;
      out_tag   <= '0;
      out_err   <= 1'b0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_data <= res_data;
        out_tag  <= s1_tag;
        out_err  <= res_err;
      end
    end
  end

endmodule

// File: tb/tb_fsign_class_unit.sv
// Directed bench for fsign_class_unit: hand-computed vectors, an expected-result
// queue checked at every output transfer, and hold checks while stalled.
module tb_fsign_class_unit;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic [31:0] in_x1;
  logic [31:0] in_x2;
  logic [4:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [4:0]  out_tag;
  logic        out_err;
  logic        busy;

  int total = 0;
  int bad   = 0;

  logic [37:0] exp_q[$];
  logic [37:0] exp_item;
  logic        hold_v = 1'b0;
  logic [39:0] hold_val;

  // Stall-burst vectors with hand-computed results.
  logic [2:0]  v_op  [8] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd3, 3'd3, 3'd4, 3'd3};
  logic [31:0] v_x1  [8] = '{32'h40000000, 32'hC0490FDB, 32'hBF800000, 32'h80000000,
                             32'h00000001, 32'h7F800000, 32'hDEADBEEF, 32'hC2280000};
  logic [31:0] v_x2  [8] = '{32'h80000000, 32'h00000000, 32'hBF800000, 32'h0,
                             32'h0, 32'h0, 32'h0, 32'h0};
  logic [31:0] v_exp [8] = '{32'hC0000000, 32'hC0490FDB, 32'h3F800000, 32'h00000008,
                             32'h00000020, 32'h00000080, 32'hDEADBEEF, 32'h00000002};

  fsign_class_unit #(.TAG_W(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_x1     (in_x1),
    .in_x2     (in_x2),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag),
    .out_err   (out_err),
    .busy      (busy)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [39:0] obs, input logic [39:0] expv);
    total++;
    assert (obs === expv)
      else begin
        bad++;
        $error("FAIL %s observed=%h expected=%h", name, obs, expv);
      end
  endtask

  // Scoreboard: every output transfer must match the head of the expected queue.
  always @(negedge clk) begin
    if (rst) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v)
        chk("stall_hold", {out_valid, out_err, out_tag, out_data}, hold_val);
      if (out_valid && out_ready) begin
        chk("result_expected", {39'd0, exp_q.size() != 0}, 40'd1);
        if (exp_q.size() != 0) begin
          exp_item = exp_q.pop_front();
          chk("result", {2'b0, out_err, out_tag, out_data}, {2'b0, exp_item});
        end
      end
      hold_v   = out_valid && !out_ready;
      hold_val = {out_valid, out_err, out_tag, out_data};
    end
  end

  // Driver: present one request, wait (bounded) for acceptance.
  task automatic send(input logic [2:0] op, input logic [31:0] x1, input logic [31:0] x2,
                      input logic [4:0] tag, input logic [31:0] ed, input logic ee);
    int n = 0;
    in_valid = 1'b1;
    in_op    = op;
    in_x1    = x1;
    in_x2    = x2;
    in_tag   = tag;
    @(negedge clk);
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("send_accept", {39'd0, in_ready}, 40'd1);
    if (in_ready) exp_q.push_back({ee, tag, ed});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((busy || exp_q.size() != 0) && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(name, {39'd0, busy}, 40'd0);
    chk("drain_queue_empty", 40'(exp_q.size()), 40'd0);
  endtask

  initial begin
    int idx;
    int guard;
    logic acc;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_op     = 3'b0;
    in_x1     = 32'h0;
    in_x2     = 32'h0;
    in_tag    = 5'd0;
    out_ready = 1'b1;
    #1;
    chk("reset_out_valid", {39'd0, out_valid}, 40'd0);
    chk("reset_in_ready", {39'd0, in_ready}, 40'd0);
    chk("reset_busy", {39'd0, busy}, 40'd0);
    chk("reset_outputs", {2'b0, out_err, out_tag, out_data}, 40'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("post_reset_in_ready", {39'd0, in_ready}, 40'd1);

    // SGNJ with exact two-cycle latency and tag echo
    send(3'd0, 32'h3F800000, 32'h80000000, 5'd7, 32'hBF800000, 1'b0);
    chk("lat_not_yet", {39'd0, out_valid}, 40'd0);
    @(posedge clk);
    #1;
    chk("lat_valid", {39'd0, out_valid}, 40'd1);
    chk("sgnj_data", {8'd0, out_data}, {8'd0, 32'hBF800000});
    chk("sgnj_tag", {35'd0, out_tag}, {35'd0, 5'd7});
    drain("drain_sgnj");

    // SGNJX / SGNJN with a NaN payload
    send(3'd2, 32'hC0400000, 32'hC0000000, 5'd1, 32'h40400000, 1'b0);
    send(3'd1, 32'h7FC00001, 32'h00000000, 5'd2, 32'hFFC00001, 1'b0);
    drain("drain_sgnjx");

    // CLASS sweep
    send(3'd3, 32'hFF800000, 32'h0, 5'd3, 32'h00000001, 1'b0);
    send(3'd3, 32'h00000000, 32'h0, 5'd4, 32'h00000010, 1'b0);
    send(3'd3, 32'h807FFFFF, 32'h0, 5'd5, 32'h00000004, 1'b0);
    send(3'd3, 32'h7F800001, 32'h0, 5'd6, 32'h00000100, 1'b0);
    send(3'd3, 32'h7FC00000, 32'h0, 5'd8, 32'h00000200, 1'b0);
    send(3'd3, 32'h3F800000, 32'h0, 5'd9, 32'h00000040, 1'b0);
    drain("drain_class");

    // Back-to-back burst with five stalled cycles
    out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1;
      in_op = v_op[idx]; in_x1 = v_x1[idx]; in_x2 = v_x2[idx]; in_tag = 5'(16 + idx);
      @(negedge clk);
      acc = in_ready;
      if (acc) exp_q.push_back({1'b0, 5'(16 + idx), v_exp[idx]});
      @(posedge clk);
      #1;
      if (acc) idx++;
    end
    in_valid = 1'b0;
    chk("stall_accepts", 40'(idx), 40'd2);
    chk("stall_in_ready", {39'd0, in_ready}, 40'd0);
    chk("stall_head", {7'd0, out_valid, out_data}, {7'd0, 1'b1, 32'hC0000000});
    out_ready = 1'b1;
    guard = 0;
    while (idx < 8 && guard < 40) begin
      in_valid = 1'b1;
      in_op = v_op[idx]; in_x1 = v_x1[idx]; in_x2 = v_x2[idx]; in_tag = 5'(16 + idx);
      @(negedge clk);
      acc = in_ready;
      if (acc) exp_q.push_back({1'b0, 5'(16 + idx), v_exp[idx]});
      @(posedge clk);
      #1;
      if (acc) idx++;
      guard++;
    end
    in_valid = 1'b0;
    chk("burst_all_accepted", 40'(idx), 40'd8);
    drain("drain_burst");

    // Illegal op, then a legal op clears out_err
    send(3'd6, 32'h12345678, 32'h0, 5'd10, 32'h00000000, 1'b1);
    send(3'd4, 32'h12345678, 32'h0, 5'd11, 32'h12345678, 1'b0);
    drain("drain_illegal");

    // Reset with both stages full drops in-flight ops
    out_ready = 1'b0;
    send(3'd4, 32'hAAAA5555, 32'h0, 5'd12, 32'hAAAA5555, 1'b0);
    send(3'd4, 32'h5555AAAA, 32'h0, 5'd13, 32'h5555AAAA, 1'b0);
    chk("full_busy", {38'd0, busy, in_ready}, {38'd0, 1'b1, 1'b0});
    rst = 1'b1;
    #1;
    exp_q.delete();
    chk("rst_out_valid", {39'd0, out_valid}, 40'd0);
    chk("rst_busy_ready", {38'd0, busy, in_ready}, 40'd0);
    chk("rst_outputs", {2'b0, out_err, out_tag, out_data}, 40'd0);
    @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("no_stale_result", {38'd0, out_valid, busy}, 40'd0);
    send(3'd0, 32'h3F800000, 32'h00000000, 5'd14, 32'h3F800000, 1'b0);
    drain("drain_after_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
